// File: rtl/branch_predictor_if.sv
// Pipeline-side bundle for branch_predictor: IF-stage lookup and MEM-stage resolve/train signals.
// master = pipeline driving PCs and outcomes, slave = predictor.
interface branch_predictor_if;
    logic [31:0] pc_if;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        mem_valid;
    logic [5:0]  opcode_mem;
    logic [5:0]  func_mem;
    logic [31:0] pc_mem;
    logic        pred_taken_mem;
    logic [31:0] pred_target_mem;
    logic        takebranch_mem;
    logic [31:0] branch_target_mem;
    logic        wrong;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output pc_if, mem_valid, opcode_mem, func_mem, pc_mem, pred_taken_mem,
               pred_target_mem, takebranch_mem, branch_target_mem,
        input  pred_taken_if, pred_target_if, wrong, branch_count, mispredict_count
    );

    modport slave (
        input  pc_if, mem_valid, opcode_mem, func_mem, pc_mem, pred_taken_mem,
               pred_target_mem, takebranch_mem, branch_target_mem,
        output pred_taken_if, pred_target_if, wrong, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; predicts at IF, trains and flags mispredicts at MEM.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input logic              CLK,
    input logic              nRST,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = 32 - IDXW - 2;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] FnJr    = 6'h08;

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0]        tag_d    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];
    logic [31:0]            target_d [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [1:0]             ctr_d    [BTB_ENTRIES];

    logic [IDXW-1:0] idx_if, idx_mem;
    logic [TAGW-1:0] tag_if, tag_mem;
    logic            hit_if, hit_mem, br, jmp, wrong_raw;
    logic            unused_pc_lsb;

    assign idx_if  = bp.pc_if[IDXW+1:2];
    assign tag_if  = bp.pc_if[31:IDXW+2];
    assign idx_mem = bp.pc_mem[IDXW+1:2];
    assign tag_mem = bp.pc_mem[31:IDXW+2];
    assign unused_pc_lsb = ^{bp.pc_if[1:0], bp.pc_mem[1:0]};

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    assign hit_if  = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    assign hit_mem = valid_q[idx_mem] && (tag_q[idx_mem] == tag_mem);

    assign bp.pred_taken_if  = nRST && hit_if && ctr_q[idx_if][1];
    assign bp.pred_target_if = bp.pred_taken_if ? target_q[idx_if] : bp.pc_if + 32'd4;

    assign br  = (bp.opcode_mem == OpBeq) || (bp.opcode_mem == OpBne);
    assign jmp = (bp.opcode_mem == OpJ) || (bp.opcode_mem == OpJal) ||
                 ((bp.opcode_mem == OpRtype) && (bp.func_mem == FnJr));

    always_comb begin
        wrong_raw = 1'b0;
        if (br) begin
            wrong_raw = (bp.pred_taken_mem != bp.takebranch_mem) ||
                        (bp.takebranch_mem && (bp.pred_target_mem != bp.branch_target_mem));
        end else if (!jmp) begin
            wrong_raw = bp.pred_taken_mem;
        end
    end

    assign bp.wrong = nRST && bp.mem_valid && wrong_raw;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.mem_valid) begin
            if (br && hit_mem) begin
                if (bp.takebranch_mem) begin
                    ctr_d[idx_mem]    = (ctr_q[idx_mem] == 2'b11) ? 2'b11 : ctr_q[idx_mem] + 2'd1;
                    target_d[idx_mem] = bp.branch_target_mem;
                end else begin
                    ctr_d[idx_mem] = (ctr_q[idx_mem] == 2'b00) ? 2'b00 : ctr_q[idx_mem] - 2'd1;
                end
            end else if (br && bp.takebranch_mem) begin
                valid_d[idx_mem]  = 1'b1;
                tag_d[idx_mem]    = tag_mem;
                target_d[idx_mem] = bp.branch_target_mem;
                ctr_d[idx_mem]    = 2'b10;
            end else if (!br && hit_mem) begin
                // A non-branch now lives at this PC: scrub the stale entry.
                valid_d[idx_mem] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_count_q, mispredict_count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (bp.mem_valid && br) branch_count_q <= branch_count_q + 32'd1;
            if (bp.wrong)           mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end

    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;
`else
    assign bp.branch_count     = 32'h0;
    assign bp.mispredict_count = 32'h0;
`endif
endmodule
